// File: rtl/vga_frame_monitor.sv
// VGA receive-side monitor: locks to HS/VS frame timing, recovers pixel X/Y/colour and
// per-frame lit-pixel counts. Define VGA_MON_BBOX_EN to add the lit-pixel bounding box outputs.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        rx_valid,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [11:0] rx_color,
  output logic        locked,
  output logic        sync_err,
  output logic        frame_start,
  output logic [18:0] frame_lit
`ifdef VGA_MON_BBOX_EN
  ,
  output logic [9:0]  bbox_x0,
  output logic [9:0]  bbox_y0,
  output logic [9:0]  bbox_x1,
  output logic [9:0]  bbox_y1
`endif
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam logic [9:0]  H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]  H_V0    = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_V1    = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_V0    = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_V1    = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [18:0] LIT_MAX = '1;

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_ALIGN  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [9:0]  h_cnt, v_cnt, h_nxt, v_nxt;
  logic        hs_q, vs_q, vs_pend;
  logic        hs_fall, vs_fall, chk_fail;
  logic        in_win, pix_vld, lit_hit, lock_edge, lit_clr;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_col;
  logic [18:0] lit_acc;

  assign hs_fall = pix_en & hs_q & ~vga_hs;
  assign vs_fall = pix_en & vs_q & ~vga_vs;
  assign pix_col = {vga_b, vga_g, vga_r};

  // Counters saturate rather than wrap so a missing sync never aliases onto a valid count.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_en) begin
      if (hs_fall)               h_nxt = '0;
      else if (h_cnt != CNT_MAX) h_nxt = h_cnt + 10'd1;
    end
    if (hs_fall) begin
      if (vs_fall || vs_pend)    v_nxt = '0;
      else if (v_cnt != CNT_MAX) v_nxt = v_cnt + 10'd1;
    end
  end

  always_comb begin
    chk_fail = 1'b0;
    if (state == S_ALIGN || state == S_LOCKED)
      chk_fail = (hs_fall && h_cnt != H_LAST) || (vs_fall && v_cnt != V_LAST);
    if (state == S_LOCKED && pix_en && !hs_fall && h_cnt == CNT_MAX)
      chk_fail = 1'b1;
    state_nxt = state;
    case (state)
      S_SEARCH: if (vs_fall) state_nxt = S_ALIGN;
      S_ALIGN: begin
        if (chk_fail)     state_nxt = S_SEARCH;
        else if (vs_fall) state_nxt = S_LOCKED;
      end
      S_LOCKED: if (chk_fail) state_nxt = S_SEARCH;
      default: state_nxt = S_SEARCH;
    endcase
  end

  assign in_win    = (h_nxt >= H_V0) && (h_nxt < H_V1) && (v_nxt >= V_V0) && (v_nxt < V_V1);
  // Gating on the next state drops rx_valid in the same cycle that locked falls.
  assign pix_vld   = pix_en && in_win && (state_nxt == S_LOCKED);
  assign pix_x     = h_nxt - H_V0;
  assign pix_y     = v_nxt - V_V0;
  assign lit_hit   = pix_vld && (pix_col != 12'h000);
  assign lock_edge = (state == S_LOCKED) && vs_fall && !chk_fail;
  assign lit_clr   = lock_edge ||
                     ((state != state_nxt) && (state == S_LOCKED || state_nxt == S_LOCKED));
  assign locked    = (state == S_LOCKED);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_SEARCH;
      h_cnt       <= '0;
      v_cnt       <= '0;
      vs_pend     <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      lit_acc     <= '0;
      rx_valid    <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_color    <= '0;
      sync_err    <= 1'b0;
      frame_start <= 1'b0;
      frame_lit   <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (pix_en) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
      end
      if (hs_fall)      vs_pend <= 1'b0;
      else if (vs_fall) vs_pend <= 1'b1;
      rx_valid <= pix_vld;
      if (pix_vld) begin
        rx_x     <= pix_x;
        rx_y     <= pix_y;
        rx_color <= pix_col;
      end
      sync_err    <= chk_fail;
      frame_start <= lock_edge;
      if (lock_edge) frame_lit <= lit_acc;
      if (lit_clr)                              lit_acc <= {18'd0, lit_hit};
      else if (lit_hit && lit_acc != LIT_MAX)   lit_acc <= lit_acc + 19'd1;
    end
  end

`ifdef VGA_MON_BBOX_EN
  logic [9:0] bx0, by0, bx1, by1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bx0     <= '1;
      by0     <= '1;
      bx1     <= '0;
      by1     <= '0;
      bbox_x0 <= '0;
      bbox_y0 <= '0;
      bbox_x1 <= '0;
      bbox_y1 <= '0;
    end else begin
      if (lock_edge) begin
        bbox_x0 <= bx0;
        bbox_y0 <= by0;
        bbox_x1 <= bx1;
        bbox_y1 <= by1;
      end
      if (lit_clr) begin
        bx0 <= lit_hit ? pix_x : 10'h3FF;
        by0 <= lit_hit ? pix_y : 10'h3FF;
        bx1 <= lit_hit ? pix_x : 10'h000;
        by1 <= lit_hit ? pix_y : 10'h000;
      end else if (lit_hit) begin
        if (pix_x < bx0) bx0 <= pix_x;
        if (pix_y < by0) by0 <= pix_y;
        if (pix_x > bx1) bx1 <= pix_x;
        if (pix_y > by1) by1 <= pix_y;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a shrunken 25x19 timing so whole frames stay short:
// frame-level vector table plus hand sequences for mid-frame reset and HS loss.
module tb_vga_frame_monitor;
  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HSY = 4;
  localparam int HB  = 3;
  localparam int VA  = 12;
  localparam int VF  = 2;
  localparam int VSY = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HF + HSY + HB;  // 25
  localparam int VT  = VA + VF + VSY + VB;  // 19
  localparam int PX  = HA * VA;             // 192
  localparam int PAD_LIT = 16;              // 2 paddles x 2 cols x 4 rows
  localparam int GRD_LIT = 191;             // gradient is black only at (0,0)

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        rx_valid, locked, sync_err, frame_start;
  logic [9:0]  rx_x, rx_y;
  logic [11:0] rx_color;
  logic [18:0] frame_lit;
`ifdef VGA_MON_BBOX_EN
  logic [9:0]  bbox_x0, bbox_y0, bbox_x1, bbox_y1;
`endif

  vga_frame_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(pix_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y), .rx_color(rx_color),
    .locked(locked), .sync_err(sync_err), .frame_start(frame_start), .frame_lit(frame_lit)
`ifdef VGA_MON_BBOX_EN
    , .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int pat = 0;
  int n_pass = 0, n_tot = 0;
  int n_valid = 0, n_lit = 0, n_bad = 0, n_err = 0, n_fs = 0, n_corner = 0;
  logic pe_q = 1'b0;

  function automatic logic [11:0] color_at(input int p, input int x, input int y);
    logic [3:0] xr, yr;
    xr = 4'(x);
    yr = 4'(y);
    case (p)
      1: return ((x < 2 || x >= HA - 2) && y >= 4 && y < 8) ? 12'hFFF : 12'h000;
      2: return {xr ^ yr, yr, xr};
      default: return 12'h000;
    endcase
  endfunction

  always @(posedge CLOCK_50) pe_q <= pix_en;

  // Every recovered pixel must follow a pix_en sample by one cycle and carry the colour driven there.
  always @(negedge CLOCK_50) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      if (rx_color != 12'h000) n_lit++;
      if (!pe_q || !locked || int'(rx_x) >= HA || int'(rx_y) >= VA ||
          rx_color != color_at(pat, int'(rx_x), int'(rx_y)))
        n_bad++;
      if (pat == 1 && rx_x == 10'd0 && rx_y == 10'd4 && rx_color == 12'hFFF) n_corner++;
    end
    if (sync_err === 1'b1)    n_err++;
    if (frame_start === 1'b1) n_fs++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One pixel: pix_en for one cycle, then a cycle of inverted junk that must be ignored.
  task automatic drive_pix(input logic hs, input logic vs, input logic [11:0] c);
    @(negedge CLOCK_50);
    pix_en = 1'b1;
    vga_hs = hs;
    vga_vs = vs;
    {vga_b, vga_g, vga_r} = c;
    @(negedge CLOCK_50);
    pix_en = 1'b0;
    vga_hs = ~hs;
    vga_vs = ~vs;
    {vga_b, vga_g, vga_r} = ~c;
  endtask

  task automatic drive_line(input int v, input int h_from, input int h_to);
    int x, y;
    logic [11:0] c;
    for (int h = h_from; h < h_to; h++) begin
      x = h - (HSY + HB);
      y = v - (VSY + VB);
      c = (x >= 0 && x < HA && y >= 0 && y < VA) ? color_at(pat, x, y) : 12'h000;
      drive_pix(h >= HSY, v >= VSY, c);
    end
  endtask

  task automatic drive_frame(input int nl, input int bad, input int blen);
    for (int v = 0; v < nl; v++) drive_line(v, 0, (v == bad) ? blen : HT);
  endtask

  typedef struct {
    int nl; int bad; int blen; int p;
    int e_lock; int e_err; int e_fs; int e_valid; int e_lit; int e_fl;
  } frame_t;

  initial begin
    frame_t tbl [12];
    int b_valid, b_lit, b_bad, b_err, b_fs, b_corner;

    //         nl    bad blen    pat lock err fs valid  lit      frame_lit
    tbl[0]  = '{VT,   -1, HT,     0,  0,   0,  0, 0,     0,       0};
    tbl[1]  = '{VT,   -1, HT,     0,  1,   0,  0, PX,    0,       0};
    tbl[2]  = '{VT,   -1, HT,     1,  1,   0,  1, PX,    PAD_LIT, 0};
    tbl[3]  = '{VT,   -1, HT,     2,  1,   0,  1, PX,    GRD_LIT, PAD_LIT};
    tbl[4]  = '{VT,    8, HT - 2, 0,  0,   1,  1, 4*HA,  0,       GRD_LIT};
    tbl[5]  = '{VT,   -1, HT,     0,  0,   0,  0, 0,     0,       GRD_LIT};
    tbl[6]  = '{VT,   -1, HT,     1,  1,   0,  0, PX,    PAD_LIT, GRD_LIT};
    tbl[7]  = '{VT-1, -1, HT,     0,  1,   0,  1, PX,    0,       PAD_LIT};
    tbl[8]  = '{VT,   -1, HT,     0,  0,   1,  0, 0,     0,       PAD_LIT};
    tbl[9]  = '{VT,   -1, HT,     0,  0,   0,  0, 0,     0,       PAD_LIT};
    tbl[10] = '{VT,   -1, HT,     2,  1,   0,  0, PX,    GRD_LIT, PAD_LIT};
    tbl[11] = '{VT,   -1, HT,     0,  1,   0,  1, PX,    0,       GRD_LIT};

    repeat (3) @(negedge CLOCK_50);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset locked", int'(locked), 0);
    check("reset sync_err", int'(sync_err), 0);
    check("reset frame_start", int'(frame_start), 0);
    check("reset frame_lit", int'(frame_lit), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      b_valid = n_valid; b_lit = n_lit; b_bad = n_bad;
      b_err = n_err; b_fs = n_fs; b_corner = n_corner;
      pat = tbl[i].p;
      drive_frame(tbl[i].nl, tbl[i].bad, tbl[i].blen);
      check($sformatf("f%0d locked", i), int'(locked), tbl[i].e_lock);
      check($sformatf("f%0d sync_err pulses", i), n_err - b_err, tbl[i].e_err);
      check($sformatf("f%0d frame_start pulses", i), n_fs - b_fs, tbl[i].e_fs);
      check($sformatf("f%0d rx_valid pixels", i), n_valid - b_valid, tbl[i].e_valid);
      check($sformatf("f%0d lit pixels seen", i), n_lit - b_lit, tbl[i].e_lit);
      check($sformatf("f%0d frame_lit", i), int'(frame_lit), tbl[i].e_fl);
      check($sformatf("f%0d bad pixels", i), n_bad - b_bad, 0);
      if (i == 2) check("paddle corner (0,4) FFF", n_corner - b_corner, 1);
`ifdef VGA_MON_BBOX_EN
      if (i == 2) begin
        check("bbox black x0", int'(bbox_x0), 1023);
        check("bbox black y0", int'(bbox_y0), 1023);
        check("bbox black x1", int'(bbox_x1), 0);
        check("bbox black y1", int'(bbox_y1), 0);
      end
      if (i == 3) begin
        check("bbox paddle x0", int'(bbox_x0), 0);
        check("bbox paddle y0", int'(bbox_y0), 4);
        check("bbox paddle x1", int'(bbox_x1), HA - 1);
        check("bbox paddle y1", int'(bbox_y1), 7);
      end
`endif
    end

    // Reset mid-frame, part way along visible line y=3 (frame line 8).
    pat = 2;
    for (int v = 0; v < 8; v++) drive_line(v, 0, HT);
    drive_line(8, 0, 13);
    check("pre-reset rx_x", int'(rx_x), 5);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid reset locked", int'(locked), 0);
    check("mid reset rx_valid", int'(rx_valid), 0);
    check("mid reset rx_x", int'(rx_x), 0);
    check("mid reset rx_y", int'(rx_y), 0);
    check("mid reset rx_color", int'(rx_color), 0);
    check("mid reset frame_lit", int'(frame_lit), 0);
    check("mid reset sync_err", int'(sync_err), 0);
    check("mid reset frame_start", int'(frame_start), 0);
    reset = 1'b0;
    b_valid = n_valid;
    drive_line(8, 13, HT);
    for (int v = 9; v < VT; v++) drive_line(v, 0, HT);
    drive_frame(VT, -1, HT);
    check("post reset align rx_valid", n_valid - b_valid, 0);
    check("post reset align locked", int'(locked), 0);
    b_valid = n_valid;
    b_bad = n_bad;
    drive_frame(VT, -1, HT);
    check("post reset relock", int'(locked), 1);
    check("post reset relock pixels", n_valid - b_valid, PX);
    check("post reset relock frame_lit", int'(frame_lit), 0);
    check("post reset bad pixels", n_bad - b_bad, 0);

    // HS lost while locked: counter saturates at 1023 and must flag once.
    b_err = n_err;
    for (int h = 0; h < 1100; h++) drive_pix(h >= HSY, 1'b1, 12'h000);
    check("hs loss sync_err pulses", n_err - b_err, 1);
    check("hs loss locked", int'(locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
